// File: rtl/adpcm_rom_fetch.sv
// adpcm_rom_fetch: fetches ADPCM sample bytes from cartridge V ROM over the
// multiplexed RAD/RA_L/RA_U/RMPX/nSDROE bus and queues them in a small FIFO
// for the ADPCM decoder (valid/ready handshake).
// Optional feature macro: ADPCM_FETCH_LOOP_EN adds a LOOP input that makes the
// fetch wrap from END_ADDR back to START_ADDR until STOP or RESET.
module adpcm_rom_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROE_CYCLES = 2
) (
  input  logic        CLK_8M,
  input  logic        RESET,
  input  logic        START,
  input  logic        STOP,
  input  logic [23:0] START_ADDR,
  input  logic [23:0] END_ADDR,
`ifdef ADPCM_FETCH_LOOP_EN
  input  logic        LOOP,
`endif
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  SAMPLE_DATA,
  output logic        SAMPLE_VALID,
  input  logic        SAMPLE_READY,
  inout  logic [7:0]  RAD,
  output logic [1:0]  RA_L,
  output logic [3:0]  RA_U,
  output logic        RMPX,
  output logic        nSDROE
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned RCW = (ROE_CYCLES > 1) ? $clog2(ROE_CYCLES) : 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [RCW-1:0] ROE_LAST = RCW'(ROE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_ALO, S_ALO_L, S_AHI, S_AHI_L, S_RD, S_CAP
  } state_t;

  state_t          state_q, state_d;
  logic [23:0]     addr_q, addr_d;
  logic [23:0]     end_q, end_d;
`ifdef ADPCM_FETCH_LOOP_EN
  logic [23:0]     start_q, start_d;
  logic            loop_q, loop_d;
`endif
  logic [RCW-1:0]  roe_q, roe_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            stop_pend_q, stop_pend_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      last_q, last_d;

  logic            push, pop, space_ok, at_end;
  logic            rad_oe;
  logic [7:0]      rad_out;

  // Sample FIFO: push on CAP, pop on VALID&READY; last popped byte is held for SAMPLE_DATA when empty
  always_comb begin
    push     = (state_q == S_CAP);
    pop      = (count_q != '0) && SAMPLE_READY;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = rdata_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // count_d already includes the byte being pushed in CAP, so a free slot here
  // means the next fetched byte is guaranteed room
  assign space_ok = (count_d < DEPTH_C);
  assign at_end   = (addr_q == end_q);

  // Fetch sequencer: next state, address progression, DONE and abort handling
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    end_d       = end_q;
`ifdef ADPCM_FETCH_LOOP_EN
    start_d     = start_q;
    loop_d      = loop_q;
`endif
    roe_d       = roe_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q | STOP;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (START && !STOP) begin
          if (END_ADDR < START_ADDR) begin
            done_d = 1'b1;
          end else begin
            addr_d  = START_ADDR;
            end_d   = END_ADDR;
`ifdef ADPCM_FETCH_LOOP_EN
            start_d = START_ADDR;
            loop_d  = LOOP;
`endif
            state_d = space_ok ? S_ALO : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (space_ok) begin
          state_d = S_ALO;
        end
      end
      S_ALO:   state_d = S_ALO_L;
      S_ALO_L: state_d = S_AHI;
      S_AHI:   state_d = S_AHI_L;
      S_AHI_L: begin
        roe_d   = '0;
        state_d = S_RD;
      end
      S_RD: begin
        if (roe_q == ROE_LAST) begin
          rdata_d = RAD;
          state_d = S_CAP;
        end else begin
          roe_d = roe_q + RCW'(1);
        end
      end
      S_CAP: begin
        addr_d = addr_q + 24'd1;
        if (at_end) begin
          done_d = 1'b1;
`ifdef ADPCM_FETCH_LOOP_EN
          if (loop_q) begin
            addr_d = start_q;
          end
`endif
        end
        if (stop_pend_q || STOP) begin
          state_d = S_IDLE;
`ifdef ADPCM_FETCH_LOOP_EN
        end else if (at_end && !loop_q) begin
`else
        end else if (at_end) begin
`endif
          state_d = S_IDLE;
        end else begin
          state_d = space_ok ? S_ALO : S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive decoded from the state register so every pin is glitch-aligned to the clock
  always_comb begin
    rad_oe  = 1'b0;
    rad_out = '0;
    RA_L    = '0;
    RA_U    = '0;
    RMPX    = 1'b0;
    nSDROE  = 1'b1;
    case (state_q)
      S_ALO, S_ALO_L: begin
        rad_oe  = 1'b1;
        rad_out = addr_q[7:0];
        RA_L    = addr_q[9:8];
        RMPX    = (state_q == S_ALO_L);
      end
      S_AHI, S_AHI_L: begin
        rad_oe  = 1'b1;
        rad_out = addr_q[17:10];
        RA_L    = addr_q[19:18];
        RA_U    = addr_q[23:20];
        RMPX    = (state_q == S_AHI);
      end
      S_RD: nSDROE = 1'b0;
      default: ;
    endcase
  end

  assign RAD          = rad_oe ? rad_out : 'z;
  assign BUSY         = (state_q != S_IDLE);
  assign DONE         = done_q;
  assign SAMPLE_VALID = (count_q != '0);
  assign SAMPLE_DATA  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

  // State, address and FIFO registers with synchronous reset
  always_ff @(posedge CLK_8M) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      end_q       <= '0;
`ifdef ADPCM_FETCH_LOOP_EN
      start_q     <= '0;
      loop_q      <= 1'b0;
`endif
      roe_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      end_q       <= end_d;
`ifdef ADPCM_FETCH_LOOP_EN
      start_q     <= start_d;
      loop_q      <= loop_d;
`endif
      roe_q       <= roe_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_adpcm_rom_fetch.sv
// Self-checking bench for adpcm_rom_fetch: external V1 address latches and a
// ROM returning addr[7:0] are modelled here; expected streams come from the
// address range itself.
module tb_adpcm_rom_fetch;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ROE   = 2;
  localparam int unsigned BPER  = 5 + ROE;

  logic        CLK_8M = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        SAMPLE_READY = 1'b0;
  logic [23:0] START_ADDR = '0;
  logic [23:0] END_ADDR = '0;
`ifdef ADPCM_FETCH_LOOP_EN
  logic        LOOP = 1'b0;
`endif
  logic        BUSY, DONE, SAMPLE_VALID, RMPX, nSDROE;
  logic [7:0]  SAMPLE_DATA;
  logic [1:0]  RA_L;
  logic [3:0]  RA_U;
  wire  [7:0]  RAD;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [9:0]  lat_lo = '0;
  logic [13:0] lat_hi = '0;
  logic [9:0]  lo_log [$];
  logic [13:0] hi_log [$];
  logic [7:0]  got [$];
  int          done_cnt = 0;
  int          done_cyc [$];
  int          fall_cyc [$];
  int          low_len [$];
  int          low_run = 0;
  logic        prev_oe = 1'b1;
  logic [23:0] exp_addr [$];

  adpcm_rom_fetch #(.FIFO_DEPTH(DEPTH), .ROE_CYCLES(ROE)) dut (
    .CLK_8M(CLK_8M), .RESET(RESET), .START(START), .STOP(STOP),
    .START_ADDR(START_ADDR), .END_ADDR(END_ADDR),
`ifdef ADPCM_FETCH_LOOP_EN
    .LOOP(LOOP),
`endif
    .BUSY(BUSY), .DONE(DONE), .SAMPLE_DATA(SAMPLE_DATA), .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY), .RAD(RAD), .RA_L(RA_L), .RA_U(RA_U),
    .RMPX(RMPX), .nSDROE(nSDROE)
  );

  always #5 CLK_8M = ~CLK_8M;
  always @(posedge CLK_8M) cyc <= cyc + 1;

  // External V1 latches and ROM
  always @(posedge RMPX) begin
    lat_lo = {RA_L, RAD};
    lo_log.push_back(lat_lo);
  end
  always @(negedge RMPX) begin
    lat_hi = {RA_U, RA_L, RAD};
    hi_log.push_back(lat_hi);
  end
  assign RAD = nSDROE ? 8'hzz : lat_lo[7:0];

  // Passive monitors sampled on the inactive edge
  always @(negedge CLK_8M) begin
    if (SAMPLE_VALID && SAMPLE_READY && !RESET) got.push_back(SAMPLE_DATA);
    if (DONE) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (!nSDROE && prev_oe) fall_cyc.push_back(cyc);
    if (!nSDROE) low_run++;
    else if (!prev_oe) begin
      low_len.push_back(low_run);
      low_run = 0;
    end
    prev_oe = nSDROE;
    if (!nSDROE) begin
      n_checks++;
      if (dut.rad_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL bus_contention at cyc %0d: rad_oe=%b while nSDROE low, required 0", cyc, dut.rad_oe);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK_8M);
    #1;
  endtask

  task automatic clear_logs();
    lo_log.delete(); hi_log.delete(); got.delete();
    done_cyc.delete(); fall_cyc.delete(); low_len.delete();
    done_cnt = 0;
  endtask

  task automatic start_range(input logic [23:0] s, input logic [23:0] e);
    START_ADDR = s;
    END_ADDR   = e;
    START      = 1'b1;
    start_cyc  = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_rdy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rand_rdy) SAMPLE_READY = 1'($urandom_range(0, 1));
      tick();
      if (!BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    SAMPLE_READY = 1'b1;
    repeat (DEPTH + 3) tick();
  endtask

  // Reference: the byte addresses a range should produce, in order
  task automatic model_range(input logic [23:0] s, input logic [23:0] e);
    logic [23:0] a;
    exp_addr.delete();
    if (e >= s) begin
      a = s;
      exp_addr.push_back(a);
      while (a != e) begin
        a = a + 24'd1;
        exp_addr.push_back(a);
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    n_checks++;
    if ({BUSY, DONE, SAMPLE_VALID, RMPX, nSDROE} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_ctrl {BUSY,DONE,VALID,RMPX,nSDROE}=%b required 00001", {BUSY, DONE, SAMPLE_VALID, RMPX, nSDROE});
    end
    n_checks++;
    if ({RA_U, RA_L} !== 6'b0 || dut.rad_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus RA_U=%h RA_L=%h rad_oe=%b required 0 0 0", RA_U, RA_L, dut.rad_oe);
    end
    SAMPLE_READY = 1'b0;
    start_range(24'h000100, 24'h0001FF);
    repeat (9) tick();
    n_checks++;
    if (SAMPLE_VALID !== 1'b1 || BUSY !== 1'b1 || RMPX !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefetch VALID=%b BUSY=%b RMPX=%b required 1 1 1", SAMPLE_VALID, BUSY, RMPX);
    end
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    n_checks++;
    if ({BUSY, SAMPLE_VALID, RMPX, nSDROE, dut.rad_oe} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_midfetch {BUSY,VALID,RMPX,nSDROE,rad_oe}=%b required 00010", {BUSY, SAMPLE_VALID, RMPX, nSDROE, dut.rad_oe});
    end
  endtask

  task automatic test_addressing();
    bit ok;
    clear_logs();
    SAMPLE_READY = 1'b1;
    model_range(24'h123456, 24'h123458);
    start_range(24'h123456, 24'h123458);
    wait_idle(60, 1'b0, ok);
    drain();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL addr_timeout BUSY=%b required 0", BUSY); end
    n_checks++;
    if (lo_log.size() !== exp_addr.size() || hi_log.size() !== exp_addr.size() || got.size() !== exp_addr.size()) begin
      n_fail++;
      $display("FAIL addr_counts lo=%0d hi=%0d data=%0d required %0d", lo_log.size(), hi_log.size(), got.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        n_checks++;
        if (lo_log[i] !== exp_addr[i][9:0] || hi_log[i] !== exp_addr[i][23:10] || got[i] !== exp_addr[i][7:0]) begin
          n_fail++;
          $display("FAIL addr_byte%0d lo=%h hi=%h data=%h required %h %h %h", i, lo_log[i], hi_log[i], got[i],
                   exp_addr[i][9:0], exp_addr[i][23:10], exp_addr[i][7:0]);
        end
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL addr_done count=%0d required 1", done_cnt); end
  endtask

  task automatic test_timing();
    bit ok;
    clear_logs();
    SAMPLE_READY = 1'b1;
    start_range(24'h000200, 24'h000204);
    wait_idle(80, 1'b0, ok);
    drain();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timing_timeout BUSY=%b required 0", BUSY); end
    n_checks++;
    if (fall_cyc.size() !== 5 || low_len.size() !== 5) begin
      n_fail++;
      $display("FAIL timing_counts falls=%0d lows=%0d required 5 5", fall_cyc.size(), low_len.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (low_len[i] !== int'(ROE)) begin
          n_fail++;
          $display("FAIL timing_low%0d got %0d clocks required %0d", i, low_len[i], ROE);
        end
        if (i > 0) begin
          n_checks++;
          if (fall_cyc[i] - fall_cyc[i-1] !== int'(BPER)) begin
            n_fail++;
            $display("FAIL timing_period%0d got %0d clocks required %0d", i, fall_cyc[i] - fall_cyc[i-1], BPER);
          end
        end
      end
    end
    n_checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] - start_cyc !== int'(5 * BPER + 1)) begin
      n_fail++;
      $display("FAIL timing_done pulses=%0d latency=%0d required 1 %0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1, 5 * BPER + 1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    SAMPLE_READY = 1'b0;
    model_range(24'h001000, 24'h001009);
    start_range(24'h001000, 24'h001009);
    repeat (80) tick();
    n_checks++;
    if (lo_log.size() !== int'(DEPTH)) begin
      n_fail++;
      $display("FAIL bp_stalled_fetches got %0d required %0d", lo_log.size(), DEPTH);
    end
    n_checks++;
    if ({BUSY, SAMPLE_VALID, nSDROE, RMPX} !== 4'b1110) begin
      n_fail++;
      $display("FAIL bp_hold {BUSY,VALID,nSDROE,RMPX}=%b required 1110", {BUSY, SAMPLE_VALID, nSDROE, RMPX});
    end
    SAMPLE_READY = 1'b1;
    wait_idle(150, 1'b0, ok);
    drain();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout BUSY=%b required 0", BUSY); end
    n_checks++;
    if (got.size() !== exp_addr.size() || lo_log.size() !== exp_addr.size()) begin
      n_fail++;
      $display("FAIL bp_counts data=%0d fetches=%0d required %0d", got.size(), lo_log.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_addr[i][7:0]) begin
          n_fail++;
          $display("FAIL bp_byte%0d got %h required %h", i, got[i], exp_addr[i][7:0]);
        end
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done count=%0d required 1", done_cnt); end
  endtask

  task automatic test_abort();
    bit ok;
    int busy_seen;
    clear_logs();
    SAMPLE_READY = 1'b1;
    start_range(24'h002000, 24'h002007);
    for (int i = 0; i < 40 && fall_cyc.size() < 2; i++) tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    wait_idle(20, 1'b0, ok);
    drain();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_timeout BUSY=%b required 0", BUSY); end
    n_checks++;
    if (got.size() !== 2 || lo_log.size() !== 2) begin
      n_fail++;
      $display("FAIL abort_counts data=%0d fetches=%0d required 2 2", got.size(), lo_log.size());
    end else begin
      n_checks++;
      if (got[0] !== 8'h00 || got[1] !== 8'h01) begin
        n_fail++;
        $display("FAIL abort_data got %h %h required 00 01", got[0], got[1]);
      end
    end
    n_checks++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done count=%0d required 0", done_cnt); end
    // START and STOP together while idle: no fetch
    clear_logs();
    START_ADDR = 24'h003000;
    END_ADDR   = 24'h003003;
    START = 1'b1;
    STOP  = 1'b1;
    tick();
    START = 1'b0;
    STOP  = 1'b0;
    busy_seen = 0;
    repeat (10) begin
      if (BUSY) busy_seen++;
      tick();
    end
    n_checks++;
    if (busy_seen !== 0 || lo_log.size() !== 0 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL start_stop busy_cycles=%0d fetches=%0d done=%0d required 0 0 0", busy_seen, lo_log.size(), done_cnt);
    end
  endtask

  task automatic test_boundary();
    bit ok;
    int busy_seen;
    // END < START: DONE only, one cycle later
    clear_logs();
    start_range(24'h005000, 24'h004FFF);
    busy_seen = 0;
    repeat (6) begin
      if (BUSY) busy_seen++;
      tick();
    end
    n_checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] - start_cyc !== 1) begin
      n_fail++;
      $display("FAIL empty_done pulses=%0d latency=%0d required 1 1", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - start_cyc : -1);
    end
    n_checks++;
    if (busy_seen !== 0 || lo_log.size() !== 0 || fall_cyc.size() !== 0) begin
      n_fail++;
      $display("FAIL empty_bus busy_cycles=%0d rmpx_rises=%0d roe_falls=%0d required 0 0 0", busy_seen, lo_log.size(), fall_cyc.size());
    end
    // Single byte at the top of the address space
    clear_logs();
    SAMPLE_READY = 1'b1;
    start_range(24'hFFFFFF, 24'hFFFFFF);
    wait_idle(30, 1'b0, ok);
    drain();
    n_checks++;
    if (!ok || got.size() !== 1 || done_cnt !== 1 || hi_log.size() !== 1) begin
      n_fail++;
      $display("FAIL single_counts ok=%0d data=%0d done=%0d hi=%0d required 1 1 1 1", ok, got.size(), done_cnt, hi_log.size());
    end else begin
      n_checks++;
      if (got[0] !== 8'hFF || lo_log[0] !== 10'h3FF || hi_log[0] !== 14'h3FFF) begin
        n_fail++;
        $display("FAIL single_value data=%h lo=%h hi=%h required ff 3ff 3fff", got[0], lo_log[0], hi_log[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] s, e;
    int len;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      s   = 24'($urandom);
      len = $urandom_range(1, 7);
      e   = s + 24'(len - 1);
      if (e < s) e = 24'hFFFFFF;
      model_range(s, e);
      SAMPLE_READY = 1'($urandom_range(0, 1));
      start_range(s, e);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        SAMPLE_READY = 1'($urandom_range(0, 3) != 0);
        tick();
        n_checks++;
        if (lo_log.size() - got.size() > int'(DEPTH)) begin
          n_fail++;
          $display("FAIL rand%0d_overfetch outstanding=%0d required <=%0d", it, lo_log.size() - got.size(), DEPTH);
        end
        if (!BUSY) begin
          ok = 1'b1;
          break;
        end
      end
      drain();
      n_checks++;
      if (!ok || got.size() !== exp_addr.size() || hi_log.size() !== exp_addr.size() || done_cnt !== 1) begin
        n_fail++;
        $display("FAIL rand%0d_counts ok=%0d data=%0d hi=%0d done=%0d required 1 %0d %0d 1", it, ok, got.size(),
                 hi_log.size(), done_cnt, exp_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          n_checks++;
          if (got[i] !== exp_addr[i][7:0] || lo_log[i] !== exp_addr[i][9:0] || hi_log[i] !== exp_addr[i][23:10]) begin
            n_fail++;
            $display("FAIL rand%0d_byte%0d data=%h lo=%h hi=%h required %h %h %h", it, i, got[i], lo_log[i], hi_log[i],
                     exp_addr[i][7:0], exp_addr[i][9:0], exp_addr[i][23:10]);
          end
        end
      end
    end
  endtask

`ifdef ADPCM_FETCH_LOOP_EN
  task automatic test_loop();
    bit ok;
    int busy_low, n11;
    clear_logs();
    SAMPLE_READY = 1'b1;
    LOOP = 1'b1;
    start_range(24'h000010, 24'h000011);
    LOOP = 1'b0;
    busy_low = 0;
    for (int c = 0; c < 100 && done_cnt < 3; c++) begin
      if (!BUSY) busy_low++;
      tick();
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    wait_idle(20, 1'b0, ok);
    drain();
    n_checks++;
    if (!ok || busy_low !== 0) begin
      n_fail++;
      $display("FAIL loop_busy ok=%0d busy_low_cycles=%0d required 1 0", ok, busy_low);
    end
    n_checks++;
    if (done_cnt < 3 || got.size() < 6) begin
      n_fail++;
      $display("FAIL loop_progress done=%0d data=%0d required >=3 >=6", done_cnt, got.size());
    end
    n11 = 0;
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== ((i % 2 == 0) ? 8'h10 : 8'h11)) begin
        n_fail++;
        $display("FAIL loop_byte%0d got %h required %h", i, got[i], (i % 2 == 0) ? 8'h10 : 8'h11);
      end
      if (got[i] == 8'h11) n11++;
    end
    n_checks++;
    if (n11 !== done_cnt) begin
      n_fail++;
      $display("FAIL loop_wraps done=%0d required %0d", done_cnt, n11);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_addressing();
    test_timing();
    test_backpressure();
    test_abort();
    test_boundary();
    test_random();
`ifdef ADPCM_FETCH_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
